// File: rtl/channel_combiner_pkg.sv
// -----------------------------------------------------------------------------
// channel_combiner_pkg
// Shared definitions for the channel combiner: per-lane operation encoding,
// clip counter width and the averaging-exponent clamp helper.
// -----------------------------------------------------------------------------
package channel_combiner_pkg;

    // Per-lane operation select, two bits per lane on the mode bus.
    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,  // A + B
        MODE_SUB  = 2'b01,  // A - B
        MODE_RSUB = 2'b10,  // B - A
        MODE_PASS = 2'b11   // A
    } mode_e;

    // Width of each per-lane clip counter.
    localparam int CLIP_W = 16;

    // Averaging exponents above the supported maximum are treated as the maximum.
    function automatic logic [3:0] clamp_shift(input logic [3:0] shift, input int max_log2);
        if (int'(shift) > max_log2) begin
            return 4'(max_log2);
        end
        return shift;
    endfunction

endpackage

// File: rtl/channel_combiner_if.sv
// -----------------------------------------------------------------------------
// channel_combiner_if
// Sample-set bus of the channel combiner.
//   in_valid  : a sample set is present on in_a / in_b
//   in_a/in_b : packed operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid : one-cycle strobe, out_y holds a new result set
//   out_y     : packed per-lane results, held until the next result
// master = sample source / result sink, slave = the combiner.
// -----------------------------------------------------------------------------
interface channel_combiner_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic                      in_valid;
    logic [CHANNELS*WIDTH-1:0] in_a;
    logic [CHANNELS*WIDTH-1:0] in_b;
    logic                      out_valid;
    logic [CHANNELS*WIDTH-1:0] out_y;

    modport master (
        output in_valid, in_a, in_b,
        input  out_valid, out_y
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output out_valid, out_y
    );
endinterface

// File: rtl/combiner_lane.sv
// -----------------------------------------------------------------------------
// combiner_lane
// One lane of the channel combiner: S1 exact sum/difference, S2 reduction to
// WIDTH bits (saturate or wrap) with overflow flag, S3 boxcar accumulator with
// dump-and-shift, and the saturating clip counter.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   s0_valid, a, b    : incoming sample and operands, mode = lane operation
//   s1_valid, s1_sat  : S1 holds valid data / saturation mode captured with it
//   s2_valid          : S2 holds valid data (drives accumulate and clip count)
//   acc_restart       : discard the partial accumulation before adding
//   acc_dump          : this sample completes the block, output the average
//   shift             : averaging exponent applied on dump
//   clr_stats         : clear the clip counter (wins over a clip)
//   y, clip_cnt       : averaged result, clip count
// -----------------------------------------------------------------------------
module combiner_lane
    import channel_combiner_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s0_valid,
    input  logic        [WIDTH-1:0]  a,
    input  logic        [WIDTH-1:0]  b,
    input  mode_e                    mode,
    input  logic                     s1_valid,
    input  logic                     s1_sat,
    input  logic                     s2_valid,
    input  logic                     acc_restart,
    input  logic                     acc_dump,
    input  logic        [3:0]        shift,
    input  logic                     clr_stats,
    output logic        [WIDTH-1:0]  y,
    output logic        [CLIP_W-1:0] clip_cnt
);

    localparam int ACC_W = WIDTH + MAX_LOG2;
    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH:0]    s1_res_q, s1_res_d;
    logic        [WIDTH-1:0]  s2_smp_q, s2_smp_d;
    logic                     s2_ovf_q, s2_ovf_d;
    logic signed [ACC_W-1:0]  acc_q,    acc_d;
    logic        [WIDTH-1:0]  y_q,      y_d;
    logic        [CLIP_W-1:0] clip_q,   clip_d;

    logic signed [WIDTH:0]    a_ext, b_ext;
    logic                     ovf;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_avg;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        s1_res_d = s1_res_q;
        s2_smp_d = s2_smp_q;
        s2_ovf_d = s2_ovf_q;
        acc_d    = acc_q;
        y_d      = y_q;
        clip_d   = clip_q;

        // S1: one extra bit holds any sum or difference of two WIDTH-bit values.
        a_ext = {a[WIDTH-1], a};
        b_ext = {b[WIDTH-1], b};
        if (s0_valid) begin
            case (mode)
                MODE_ADD:  s1_res_d = a_ext + b_ext;
                MODE_SUB:  s1_res_d = a_ext - b_ext;
                MODE_RSUB: s1_res_d = b_ext - a_ext;
                default:   s1_res_d = a_ext;
            endcase
        end

        // S2: the value fits in WIDTH bits only when the top two bits agree.
        ovf = s1_res_q[WIDTH] != s1_res_q[WIDTH-1];
        if (s1_valid) begin
            s2_ovf_d = ovf;
            if (ovf && s1_sat) begin
                s2_smp_d = s1_res_q[WIDTH] ? NEG_MAX : POS_MAX;
            end else begin
                s2_smp_d = s1_res_q[WIDTH-1:0];
            end
        end

        // S3: a restart drops the partial block so this sample becomes sample 1.
        acc_sum = (acc_restart ? '0 : acc_q)
                + {{MAX_LOG2{s2_smp_q[WIDTH-1]}}, s2_smp_q};
        acc_avg = acc_sum >>> shift;
        if (s2_valid) begin
            if (acc_dump) begin
                acc_d = '0;
                y_d   = acc_avg[WIDTH-1:0];
            end else begin
                acc_d = acc_sum;
            end
        end

        if (clr_stats) begin
            clip_d = '0;
        end else if (s2_valid && s2_ovf_q && (clip_q != '1)) begin
            clip_d = clip_q + CLIP_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_res_q <= '0;
            s2_smp_q <= '0;
            s2_ovf_q <= 1'b0;
            acc_q    <= '0;
            y_q      <= '0;
            clip_q   <= '0;
        end else begin
            s1_res_q <= s1_res_d;
            s2_smp_q <= s2_smp_d;
            s2_ovf_q <= s2_ovf_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            clip_q   <= clip_d;
        end
    end

    assign y        = y_q;
    assign clip_cnt = clip_q;

endmodule

// File: rtl/channel_combiner.sv
// -----------------------------------------------------------------------------
// channel_combiner
// CHANNELS-lane pipelined sum/difference engine with saturate/wrap reduction,
// power-of-two boxcar averaging with decimation and per-lane clip counters.
// Ports:
//   clk       : clock, all logic on the rising edge
//   reset     : asynchronous active-low reset
//   bus       : sample-set bus (in_valid/in_a/in_b in, out_valid/out_y out)
//   mode      : per-lane operation, lane i at [2*i +: 2]
//   sat_en    : 1 = saturate on overflow, 0 = wrap
//   avg_shift : averaging exponent, N = 2^avg_shift, clamped to MAX_LOG2
//   clr_stats : synchronous clear of all clip counters
//   clip_cnt  : per-lane saturating clip counts, lane i at [i*16 +: 16]
// Latency: sample accepted at edge k is output at edge k+2 when it dumps.
// -----------------------------------------------------------------------------
module channel_combiner
    import channel_combiner_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int MAX_LOG2 = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    channel_combiner_if.slave            bus,
    input  logic [CHANNELS*2-1:0]        mode,
    input  logic                         sat_en,
    input  logic [3:0]                   avg_shift,
    input  logic                         clr_stats,
    output logic [CHANNELS*CLIP_W-1:0]   clip_cnt
);

    // The block count never exceeds 2^MAX_LOG2 - 1; one spare bit keeps the
    // 2^shift comparison value representable.
    localparam int CNT_W = MAX_LOG2 + 1;

    logic             s1_valid_q,  s1_valid_d;
    logic             s1_sat_q,    s1_sat_d;
    logic [3:0]       s1_shift_q,  s1_shift_d;
    logic             s2_valid_q,  s2_valid_d;
    logic [3:0]       s2_shift_q,  s2_shift_d;
    logic [3:0]       cur_shift_q, cur_shift_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             out_valid_q, out_valid_d;

    logic             restart;
    logic             dump;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] last_cnt;

    always_comb begin
        // Configuration travels with the sample it was captured for.
        s1_valid_d = bus.in_valid;
        s1_sat_d   = s1_sat_q;
        s1_shift_d = s1_shift_q;
        if (bus.in_valid) begin
            s1_sat_d   = sat_en;
            s1_shift_d = clamp_shift(avg_shift, MAX_LOG2);
        end

        s2_valid_d = s1_valid_q;
        s2_shift_d = s2_shift_q;
        if (s1_valid_q) begin
            s2_shift_d = s1_shift_q;
        end

        // A changed exponent abandons the block in progress; the arriving
        // sample opens a new block under the new N.
        restart  = s2_valid_q && (s2_shift_q != cur_shift_q);
        base_cnt = restart ? '0 : cnt_q;
        last_cnt = (CNT_W'(1) << s2_shift_q) - CNT_W'(1);
        dump     = s2_valid_q && (base_cnt == last_cnt);

        cur_shift_d = cur_shift_q;
        cnt_d       = cnt_q;
        if (s2_valid_q) begin
            cur_shift_d = s2_shift_q;
            cnt_d       = dump ? '0 : base_cnt + CNT_W'(1);
        end

        out_valid_d = dump;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_sat_q    <= 1'b0;
            s1_shift_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_shift_q  <= '0;
            cur_shift_q <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sat_q    <= s1_sat_d;
            s1_shift_q  <= s1_shift_d;
            s2_valid_q  <= s2_valid_d;
            s2_shift_q  <= s2_shift_d;
            cur_shift_q <= cur_shift_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid = out_valid_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        combiner_lane #(
            .WIDTH    (WIDTH),
            .MAX_LOG2 (MAX_LOG2)
        ) u_lane (
            .clk         (clk),
            .rst_n       (reset),
            .s0_valid    (bus.in_valid),
            .a           (bus.in_a[i*WIDTH +: WIDTH]),
            .b           (bus.in_b[i*WIDTH +: WIDTH]),
            .mode        (mode_e'(mode[2*i +: 2])),
            .s1_valid    (s1_valid_q),
            .s1_sat      (s1_sat_q),
            .s2_valid    (s2_valid_q),
            .acc_restart (restart),
            .acc_dump    (dump),
            .shift       (s2_shift_q),
            .clr_stats   (clr_stats),
            .y           (bus.out_y[i*WIDTH +: WIDTH]),
            .clip_cnt    (clip_cnt[i*CLIP_W +: CLIP_W])
        );
    end

endmodule

// File: tb/tb_channel_combiner.sv
// -----------------------------------------------------------------------------
// tb_channel_combiner
// Drives directed and random sample sets into channel_combiner and compares
// out_valid, out_y and clip_cnt every cycle against a block-average model.
// -----------------------------------------------------------------------------
module tb_channel_combiner;
    import channel_combiner_pkg::*;

    localparam int W = 16;
    localparam int C = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [C*2-1:0]     mode = '0;
    logic               sat_en = 1'b0;
    logic [3:0]         avg_shift = '0;
    logic               clr_stats = 1'b0;
    logic [C*CLIP_W-1:0] clip_cnt;

    channel_combiner_if #(.WIDTH(W), .CHANNELS(C)) bus ();

    channel_combiner #(.WIDTH(W), .CHANNELS(C), .MAX_LOG2(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mode      (mode),
        .sat_en    (sat_en),
        .avg_shift (avg_shift),
        .clr_stats (clr_stats),
        .clip_cnt  (clip_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Results are scheduled two edges after acceptance in a 4-slot ring.
    bit          sv [4];
    logic [15:0] sy [4][C];
    bit          sc [4][C];
    bit          exp_valid;
    logic [15:0] exp_y [C];
    int          exp_clip [C];
    int          blk_shift;
    int          blk_cnt;
    longint      blk_sum [C];
    int          e = 0;

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            sv[s] = 0;
            for (int l = 0; l < C; l++) begin
                sc[s][l] = 0;
                sy[s][l] = '0;
            end
        end
        exp_valid = 0;
        blk_shift = 0;
        blk_cnt   = 0;
        for (int l = 0; l < C; l++) begin
            exp_y[l]    = '0;
            exp_clip[l] = 0;
            blk_sum[l]  = 0;
        end
    endtask

    task automatic model_edge(input bit v, input logic [C*W-1:0] a, input logic [C*W-1:0] b,
                              input logic [2*C-1:0] m, input bit sat, input logic [3:0] sh,
                              input bit clr);
        int s, ns, eff, ai, bi, r;
        bit clip, dump_now;
        logic signed [15:0] smp;
        s = e % 4;
        exp_valid = sv[s];
        for (int l = 0; l < C; l++) begin
            if (sv[s]) exp_y[l] = sy[s][l];
            if (clr) exp_clip[l] = 0;
            else if (sc[s][l] && exp_clip[l] < 65535) exp_clip[l]++;
            sc[s][l] = 0;
        end
        sv[s] = 0;
        if (v) begin
            eff = (int'(sh) > 8) ? 8 : int'(sh);
            if (eff != blk_shift) begin
                blk_shift = eff;
                blk_cnt   = 0;
                for (int l = 0; l < C; l++) blk_sum[l] = 0;
            end
            blk_cnt++;
            dump_now = (blk_cnt == (1 << eff));
            ns = (e + 2) % 4;
            for (int l = 0; l < C; l++) begin
                ai = int'($signed(a[l*W +: W]));
                bi = int'($signed(b[l*W +: W]));
                case (m[2*l +: 2])
                    2'b00:   r = ai + bi;
                    2'b01:   r = ai - bi;
                    2'b10:   r = bi - ai;
                    default: r = ai;
                endcase
                clip = (r > 32767) || (r < -32768);
                if (clip && sat) r = (r > 0) ? 32767 : -32768;
                smp = r[15:0];
                sc[ns][l] = clip;
                blk_sum[l] += smp;
                if (dump_now) sy[ns][l] = 16'(blk_sum[l] >>> eff);
            end
            if (dump_now) begin
                sv[ns]  = 1;
                blk_cnt = 0;
                for (int l = 0; l < C; l++) blk_sum[l] = 0;
            end
        end
        e++;
    endtask

    task automatic compare_all();
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        for (int l = 0; l < C; l++) begin
            check($sformatf("out_y[%0d]", l), 64'(bus.out_y[l*W +: W]), 64'(exp_y[l]));
            check($sformatf("clip_cnt[%0d]", l), 64'(clip_cnt[l*CLIP_W +: CLIP_W]), 64'(exp_clip[l]));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [C*W-1:0] lanes(input logic [15:0] l0, input logic [15:0] l1,
                                             input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [C*W-1:0] rnd_bus();
        logic [C*W-1:0] v;
        for (int l = 0; l < C; l++) begin
            case ($urandom_range(0, 4))
                0:       v[l*W +: W] = 16'h7FFF;
                1:       v[l*W +: W] = 16'h8000;
                default: v[l*W +: W] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic step(input bit v, input logic [C*W-1:0] a, input logic [C*W-1:0] b,
                        input logic [2*C-1:0] m, input bit sat, input logic [3:0] sh,
                        input bit clr);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        mode         = m;
        sat_en       = sat;
        avg_shift    = sh;
        clr_stats    = clr;
        @(posedge clk);
        model_edge(v, a, b, m, sat, sh, clr);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input logic [3:0] sh);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, sh, 0);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        bus.in_valid = 1'b0;
        clr_stats    = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    logic [C*W-1:0] ones;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Overflowing ADD, saturate then wrap, every lane.
        step(1, lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000),
                lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000), 8'h00, 1, 0, 0);
        idle(2, 0);
        check("add_sat_y0", 64'(bus.out_y[15:0]), 64'h7FFF);
        check("add_sat_clip0", 64'(clip_cnt[15:0]), 64'd1);
        step(1, lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000),
                lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000), 8'h00, 0, 0, 0);
        idle(2, 0);
        check("add_wrap_y0", 64'(bus.out_y[15:0]), 64'hE000);
        check("add_wrap_clip0", 64'(clip_cnt[15:0]), 64'd2);

        // Four lanes, four modes: SUB sat, RSUB, PASS, ADD.
        step(1, lanes(16'h8000, 16'd3, 16'hFFFB, 16'd100),
                lanes(16'h0001, 16'd10, 16'd9, 16'd200), 8'b00_11_10_01, 1, 0, 0);
        idle(2, 0);
        check("sub_sat_y0", 64'(bus.out_y[15:0]), 64'h8000);
        check("rsub_y1", 64'(bus.out_y[31:16]), 64'd7);
        check("pass_y2", 64'(bus.out_y[47:32]), 64'hFFFB);

        // N = 4 with bubbles: 1,2,3,6 -> 3, then -1,-1,-1,-2 -> -2.
        ones = '0;
        step(1, lanes(16'd1, 0, 0, 0), ones, 8'hFF, 1, 2, 0);
        idle(1, 2);
        step(1, lanes(16'd2, 0, 0, 0), ones, 8'hFF, 1, 2, 0);
        step(1, lanes(16'd3, 0, 0, 0), ones, 8'hFF, 1, 2, 0);
        idle(2, 2);
        step(1, lanes(16'd6, 0, 0, 0), ones, 8'hFF, 1, 2, 0);
        idle(2, 2);
        check("avg4_y0", 64'(bus.out_y[15:0]), 64'd3);
        for (int i = 0; i < 3; i++) step(1, lanes(16'hFFFF, 0, 0, 0), ones, 8'hFF, 1, 2, 0);
        step(1, lanes(16'hFFFE, 0, 0, 0), ones, 8'hFF, 1, 2, 0);
        idle(2, 2);
        check("avg4_floor_y0", 64'(bus.out_y[15:0]), 64'hFFFE);

        // Exponent change 3 -> 1 after 5 samples: partial block dropped.
        for (int i = 0; i < 5; i++) step(1, lanes(16'(i*10), 16'd1, 16'd2, 16'd3), ones, 8'hFF, 1, 3, 0);
        step(1, lanes(16'd8, 16'd1, 16'd2, 16'd3), ones, 8'hFF, 1, 1, 0);
        step(1, lanes(16'd4, 16'd1, 16'd2, 16'd3), ones, 8'hFF, 1, 1, 0);
        idle(2, 1);
        check("shift_change_y0", 64'(bus.out_y[15:0]), 64'd6);

        // Clip counter sticks at 0xFFFF, then clr_stats wins over a clip.
        async_reset();
        for (int i = 0; i < 65537; i++)
            step(1, lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000),
                    lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000), 8'h00, 1, 0, 0);
        check("clip_stick0", 64'(clip_cnt[15:0]), 64'hFFFF);
        step(1, lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000),
                lanes(16'h7000, 16'h7000, 16'h7000, 16'h7000), 8'h00, 1, 0, 1);
        check("clr_wins0", 64'(clip_cnt[15:0]), 64'd0);
        idle(2, 0);

        // Reset mid-block: a full new block is required afterwards.
        for (int i = 0; i < 2; i++) step(1, lanes(16'd40, 16'd40, 16'd40, 16'd40), ones, 8'hFF, 1, 2, 0);
        async_reset();
        check("reset_y0", 64'(bus.out_y[15:0]), 64'd0);
        for (int i = 0; i < 4; i++) step(1, lanes(16'(4*i), 16'd8, 16'd12, 16'd16), ones, 8'hFF, 1, 2, 0);
        idle(2, 2);
        check("post_reset_y0", 64'(bus.out_y[15:0]), 64'd6);

        // Random traffic: bubbles, mixed modes, saturate/wrap, exponent changes.
        for (int blk = 0; blk < 40; blk++) begin
            logic [3:0] sh;
            int len;
            sh  = (blk == 20) ? 4'd12 : 4'($urandom_range(0, 4));
            len = (blk == 20) ? 700 : 60;
            for (int i = 0; i < len; i++)
                step($urandom_range(0, 3) != 0, rnd_bus(), rnd_bus(), 8'($urandom), 1'($urandom),
                     sh, $urandom_range(0, 63) == 0);
        end
        idle(3, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/channel_combiner.md
# channel_combiner

Multi-channel, pipelined sum/difference engine with per-channel mode select, selectable saturation, power-of-two boxcar averaging with decimation, and per-channel clip counters. It sits between the instrument input ports and the output DACs, configured from the control register bank, with clip counts exported to the status bank. It generalises the two-input sum/difference path to N channels and adds registered datapath, overflow handling and averaging.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `CHANNELS`, 4: independent lanes.
- `MAX_LOG2`, 8: largest averaging exponent; the accumulator is `WIDTH+MAX_LOG2` bits.
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: a sample set is present on `in_a`/`in_b` this cycle.
- `in_a`  in  CHANNELS*WIDTH: operand A, lane i at bits [i*WIDTH +: WIDTH].
- `in_b`  in  CHANNELS*WIDTH: operand B, same packing.
- `mode`  in  CHANNELS*2: per-lane op. 00 = A+B, 01 = A−B, 10 = B−A, 11 = A pass-through.
- `sat_en`  in  1: 1 = saturate, 0 = wrap.
- `avg_shift`  in  4: averaging exponent, N = 2^avg_shift. Values above MAX_LOG2 are clamped to MAX_LOG2.
- `clr_stats`  in  1: synchronous clear of all clip counters.
- `out_valid`  out  1: `out_y` holds a new result set.
- `out_y`  out  CHANNELS*WIDTH: per-lane result.
- `clip_cnt`  out  CHANNELS*16: per-lane saturating count of clipped or wrapped samples.

## Operation
- **S1, registered on `in_valid`:**
  - Compute the `WIDTH+1`-bit exact result per lane using the current `mode`.
  - Capture `sat_en` and the clamped `avg_shift` alongside the data.
- **S2:**
  - Reduce to `WIDTH` bits. A lane overflows when the `WIDTH+1` result is outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - With saturation, clamp to 0x7FFF or 0x8000 (16-bit case). With wrap, take the low WIDTH bits.
  - Every overflow raises a one-cycle per-lane clip pulse, whether saturating or wrapping.
- **S3, accumulate and dump:**
  - Accumulate sign-extended S2 samples and count them to N.
  - On the Nth sample, output (acc + sample) >>> avg_shift. This is an arithmetic shift, truncating toward −∞.
  - The same cycle reloads the accumulator to 0 and the count to 0.
  - With avg_shift = 0, every sample passes through, one output per input.
- **avg_shift change:** if the S1-captured avg_shift differs from the value in use by S3, S3 discards its partial accumulation. It restarts counting with that sample as sample 1 under the new N. No `out_valid` is raised for the discarded block.
- **Lanes:** all lanes share `in_valid`, the S3 count and `out_valid`, so outputs stay lane-aligned.
- **`clip_cnt`:**
  - Increments by 1 per clip pulse and sticks at 0xFFFF.
  - `clr_stats` wins over a simultaneous clip pulse; the counter goes to 0.
- **Bubbles:** `in_valid` low inserts a bubble. Stages advance only with valid data; there is no backpressure.

## Timing
- **Reset (asynchronous, active-low):** all pipeline registers, accumulators, counts, `out_valid`, `out_y` and `clip_cnt` go to 0 immediately. Partial averages are lost. The first valid after release starts a fresh block.
- **Latency:** a sample accepted at edge k (`in_valid` high before edge k) reaches S1 at k, S2 at k+1 and output at k+2.
  - `out_valid` is high during cycle k+2 for a dumping sample.
  - `out_valid` lasts exactly one cycle per result. `out_y` holds its value until the next dump.
- **Throughput:** one sample set per clock. The output rate is the input rate / N.
- **Config timing:**
  - `mode`/`sat_en`/`avg_shift` take effect for the sample accepted on the same edge.
  - `clip_cnt` updates at edge k+2 for the sample accepted at k.

## Structure
- Package `channel_combiner_pkg`: the mode encoding (MODE_ADD, MODE_SUB, MODE_RSUB, MODE_PASS) and the clip counter width (16).
- Sub-module `combiner_lane`: holds S1/S2 arithmetic, the accumulator and the clip counter for one lane. Instantiate it CHANNELS times via generate.
- The top level holds the shared S3 sample count, avg_shift tracking and the `out_valid` pipeline.

## Test plan
- ADD, sat_en = 1, A = 0x7000, B = 0x7000, avg_shift = 0 → out_y = 0x7FFF at k+2, clip_cnt = 1. With sat_en = 0 the same input gives 0xE000 and clip_cnt = 2.
- SUB, A = 0x8000, B = 0x0001, saturate → 0x8000, clip. RSUB, A = 3, B = 10 → 7. PASS, A = −5 → −5. All four lanes run in different modes on the same cycle, checking lane independence.
- avg_shift = 2, lane-0 samples 1, 2, 3, 6 with gaps in `in_valid` → a single `out_valid` with out_y = 3. Samples −1, −1, −1, −2 → −2 (floor).
- avg_shift changed from 3 to 1 after 5 samples → no output for the partial block. The next output arrives after exactly 2 further samples.
- 0x10000 overflow events → clip_cnt holds 0xFFFF. `clr_stats` asserted on the same cycle as a clip pulse → 0.
- `reset` asserted mid-block between edges → outputs 0 asynchronously. After release, a full N samples are required before `out_valid`.
